// File: rtl/hslp_mul_pipe_if.sv
// Stream bundle for hslp_mul_pipe: operand/mode input stream and product output stream.
// The design takes the slave view; the traffic source/sink takes the master view.
interface hslp_mul_pipe_if #(
  parameter int W = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [3:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic [3:0]     out_mode;
  logic           out_exact;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_prod, out_mode, out_exact
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_prod, out_mode, out_exact
  );
endinterface

// File: rtl/hslp_mul_pipe.sv
// Two-stage elastic half-split multiplier: per-quadrant exact/truncated sub-products
// in S1, recombination into the 2W-bit product in S2 which drives the output stream.
module hslp_mul_pipe #(
  parameter int W     = 8,
  parameter int TRUNC = 2
) (
  input logic            clk,
  input logic            rst_n,
  hslp_mul_pipe_if.slave bus
);
  localparam int H = W / 2;
  // Mask that clears the TRUNC LSBs of an approximate sub-product.
  localparam logic [W-1:0] KEEP = {W{1'b1}} << TRUNC;

  logic [H-1:0] ah, al, bh, bl;
  logic [W-1:0] hh_c, hl_c, lh_c, ll_c;

  logic           s1_valid, s2_valid;
  logic           s1_load, s2_load;
  logic [W-1:0]   s1_hh, s1_hl, s1_lh, s1_ll;
  logic [3:0]     s1_mode, s2_mode;
  logic [W:0]     mid_c;
  logic [2*W-1:0] prod_c, s2_prod;

  assign ah = bus.in_a[W-1:H];
  assign al = bus.in_a[H-1:0];
  assign bh = bus.in_b[W-1:H];
  assign bl = bus.in_b[H-1:0];

  always_comb begin
    // NOTE: every output of this block is assigned unconditionally first, so the
    // conditional truncation below can never infer a latch.
    hh_c = {{H{1'b0}}, ah} * {{H{1'b0}}, bh};
    hl_c = {{H{1'b0}}, ah} * {{H{1'b0}}, bl};
    lh_c = {{H{1'b0}}, al} * {{H{1'b0}}, bh};
    ll_c = {{H{1'b0}}, al} * {{H{1'b0}}, bl};
    if (bus.in_mode[3]) hh_c = hh_c & KEEP;
    if (bus.in_mode[2]) hl_c = hl_c & KEEP;
    if (bus.in_mode[1]) lh_c = lh_c & KEEP;
    if (bus.in_mode[0]) ll_c = ll_c & KEEP;
  end

  // A full pipeline still accepts when the output is being consumed this cycle.
  assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);

  // Truncated quadrants never exceed their exact values, so these widths cannot overflow.
  assign mid_c  = {1'b0, s1_hl} + {1'b0, s1_lh};
  assign prod_c = {s1_hh, {W{1'b0}}} + ((2*W)'(mid_c) << H) + (2*W)'(s1_ll);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load)            s2_valid <= 1'b1;
      else if (bus.out_ready) s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so a reset mid-flight clears the
      // visible product immediately instead of leaving stale operands behind.
      s1_hh   <= '0;
      s1_hl   <= '0;
      s1_lh   <= '0;
      s1_ll   <= '0;
      s1_mode <= '0;
      s2_prod <= '0;
      s2_mode <= '0;
    end else begin
      if (s1_load) begin
        s1_hh   <= hh_c;
        s1_hl   <= hl_c;
        s1_lh   <= lh_c;
        s1_ll   <= ll_c;
        s1_mode <= bus.in_mode;
      end
      if (s2_load) begin
        s2_prod <= prod_c;
        s2_mode <= s1_mode;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_prod  = s2_prod;
  assign bus.out_mode  = s2_mode;
  assign bus.out_exact = (s2_mode == 4'b0000);
endmodule

// File: tb/tb_hslp_mul_pipe.sv
// Directed and streaming bench for hslp_mul_pipe at W=8/TRUNC=2 and W=16/TRUNC=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hslp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hslp_mul_pipe_if #(.W(8))  b8  ();
  hslp_mul_pipe_if #(.W(16)) b16 ();

  hslp_mul_pipe #(.W(8),  .TRUNC(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  hslp_mul_pipe #(.W(16), .TRUNC(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  // Reference model built directly from the quadrant/recombination rules.
  function automatic longint model(longint a, longint b, int mode, int w, int trunc);
    int     h = w / 2;
    longint m = (longint'(1) << h) - 1;
    longint q[4];
    q[0] = (a & m) * (b & m);
    q[1] = (a & m) * (b >> h);
    q[2] = (a >> h) * (b & m);
    q[3] = (a >> h) * (b >> h);
    for (int k = 0; k < 4; k++)
      if (((mode >> k) & 1) == 1) q[k] = (q[k] >> trunc) << trunc;
    return (q[3] << w) + ((q[2] + q[1]) << h) + q[0];
  endfunction

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    b8.in_valid = 1'b1;
    b8.in_a     = a;
    b8.in_b     = b;
    b8.in_mode  = m;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", b8.out_valid); end
    checks++; if (b8.out_prod !== 16'd0) begin errors++; $display("FAIL reset_out_prod got=%0d want=0", b8.out_prod); end
    checks++; if (b8.out_mode !== 4'd0) begin errors++; $display("FAIL reset_out_mode got=%b want=0000", b8.out_mode); end
    checks++; if (b8.out_exact !== 1'b1) begin errors++; $display("FAIL reset_out_exact got=%b want=1", b8.out_exact); end
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", b8.in_ready); end
    checks++; if (b16.out_valid !== 1'b0) begin errors++; $display("FAIL reset16_out_valid got=%b want=0", b16.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact();
    b8.out_ready = 1'b1;
    drive8(8'd255, 8'd255, 4'b0000);
    @(negedge clk);
    drive8(8'd0, 8'd200, 4'b0000);
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL exact_latency_early got=%b want=0", b8.out_valid); end
    @(negedge clk);
    b8.in_valid = 1'b0;
    checks++; if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL exact_max_valid got=%b want=1", b8.out_valid); end
    checks++; if (b8.out_prod !== 16'd65025) begin errors++; $display("FAIL exact_max_prod got=%0d want=65025", b8.out_prod); end
    checks++; if (b8.out_exact !== 1'b1) begin errors++; $display("FAIL exact_max_exact got=%b want=1", b8.out_exact); end
    @(negedge clk);
    checks++; if (b8.out_valid !== 1'b1 || b8.out_prod !== 16'd0) begin errors++; $display("FAIL exact_zero got valid=%b prod=%0d want valid=1 prod=0", b8.out_valid, b8.out_prod); end
    @(negedge clk);
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL exact_drain got=%b want=0", b8.out_valid); end
  endtask

  task automatic test_approx();
    drive8(8'h37, 8'h5B, 4'b1111);
    @(negedge clk);
    drive8(8'h37, 8'h5B, 4'b0001);
    @(negedge clk);
    drive8(8'h37, 8'h5B, 4'b0000);
    checks++; if (b8.out_prod !== 16'd4172 || b8.out_valid !== 1'b1) begin errors++; $display("FAIL approx_all got valid=%b prod=%0d want valid=1 prod=4172", b8.out_valid, b8.out_prod); end
    checks++; if (b8.out_exact !== 1'b0 || b8.out_mode !== 4'b1111) begin errors++; $display("FAIL approx_all_mode got exact=%b mode=%b want exact=0 mode=1111", b8.out_exact, b8.out_mode); end
    @(negedge clk);
    b8.in_valid = 1'b0;
    checks++; if (b8.out_prod !== 16'd5004 || b8.out_mode !== 4'b0001) begin errors++; $display("FAIL approx_ll got prod=%0d mode=%b want prod=5004 mode=0001", b8.out_prod, b8.out_mode); end
    @(negedge clk);
    checks++; if (b8.out_prod !== 16'd5005 || b8.out_exact !== 1'b1) begin errors++; $display("FAIL approx_none got prod=%0d exact=%b want prod=5005 exact=1", b8.out_prod, b8.out_exact); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    b8.out_ready = 1'b0;
    drive8(8'h37, 8'h5B, 4'b1111);
    @(negedge clk);
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got=%b want=1", b8.in_ready); end
    drive8(8'd255, 8'd255, 4'b0000);
    @(negedge clk);
    drive8(8'h37, 8'h5B, 4'b0000);
    checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b want=0", b8.in_ready); end
    checks++; if (b8.out_valid !== 1'b1 || b8.out_prod !== 16'd4172) begin errors++; $display("FAIL bp_head got valid=%b prod=%0d want valid=1 prod=4172", b8.out_valid, b8.out_prod); end
    @(negedge clk);
    checks++; if (b8.in_ready !== 1'b0 || b8.out_prod !== 16'd4172 || b8.out_mode !== 4'b1111) begin errors++; $display("FAIL bp_stall got ready=%b prod=%0d mode=%b want ready=0 prod=4172 mode=1111", b8.in_ready, b8.out_prod, b8.out_mode); end
    b8.out_ready = 1'b1;
    #1;
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", b8.in_ready); end
    @(negedge clk);
    b8.in_valid = 1'b0;
    checks++; if (b8.out_valid !== 1'b1 || b8.out_prod !== 16'd65025) begin errors++; $display("FAIL bp_second got valid=%b prod=%0d want valid=1 prod=65025", b8.out_valid, b8.out_prod); end
    @(negedge clk);
    checks++; if (b8.out_valid !== 1'b1 || b8.out_prod !== 16'd5005 || b8.out_mode !== 4'b0000) begin errors++; $display("FAIL bp_third got valid=%b prod=%0d mode=%b want valid=1 prod=5005 mode=0000", b8.out_valid, b8.out_prod, b8.out_mode); end
    @(negedge clk);
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b want=0", b8.out_valid); end
  endtask

  task automatic test_streaming();
    logic [15:0] e8[16];
    logic [3:0]  m8[16];
    logic [31:0] e16[16];
    logic [3:0]  m16[16];
    logic [7:0]  a8, bb8;
    logic [15:0] a16, bb16;
    logic [3:0]  m;
    b8.out_ready  = 1'b1;
    b16.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i >= 2 && i < 18) begin
        checks++; if (b8.out_valid !== 1'b1 || b8.out_prod !== e8[i-2] || b8.out_mode !== m8[i-2]) begin
          errors++; $display("FAIL stream8[%0d] got valid=%b prod=%0d mode=%b want valid=1 prod=%0d mode=%b", i-2, b8.out_valid, b8.out_prod, b8.out_mode, e8[i-2], m8[i-2]); end
        checks++; if (b16.out_valid !== 1'b1 || b16.out_prod !== e16[i-2] || b16.out_mode !== m16[i-2]) begin
          errors++; $display("FAIL stream16[%0d] got valid=%b prod=%0d mode=%b want valid=1 prod=%0d mode=%b", i-2, b16.out_valid, b16.out_prod, b16.out_mode, e16[i-2], m16[i-2]); end
      end
      if (i == 18) begin
        checks++; if (b8.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got v8=%b v16=%b want 0 0", b8.out_valid, b16.out_valid); end
      end
      if (i < 16) begin
        a8   = 8'($urandom_range(0, 255));
        bb8  = 8'($urandom_range(0, 255));
        m    = 4'($urandom_range(0, 15));
        m8[i] = m;
        e8[i] = 16'(model(longint'(a8), longint'(bb8), int'(m), 8, 2));
        drive8(a8, bb8, m);
        a16  = 16'($urandom_range(0, 65535));
        bb16 = 16'($urandom_range(0, 65535));
        m    = 4'($urandom_range(0, 15));
        m16[i] = m;
        e16[i] = 32'(model(longint'(a16), longint'(bb16), int'(m), 16, 4));
        b16.in_valid = 1'b1;
        b16.in_a     = a16;
        b16.in_b     = bb16;
        b16.in_mode  = m;
      end else begin
        b8.in_valid  = 1'b0;
        b16.in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    b8.out_ready = 1'b1;
    drive8(8'd255, 8'd255, 4'b0000);
    @(negedge clk);
    drive8(8'h37, 8'h5B, 4'b1111);
    @(negedge clk);
    b8.in_valid = 1'b0;
    checks++; if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b want=1", b8.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b8.out_valid !== 1'b0 || b8.out_prod !== 16'd0) begin errors++; $display("FAIL rst_async got valid=%b prod=%0d want valid=0 prod=0", b8.out_valid, b8.out_prod); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", b8.in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d] got=%b want=0", i, b8.out_valid); end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    b8.in_valid   = 1'b0;
    b8.in_a       = '0;
    b8.in_b       = '0;
    b8.in_mode    = '0;
    b8.out_ready  = 1'b1;
    b16.in_valid  = 1'b0;
    b16.in_a      = '0;
    b16.in_b      = '0;
    b16.in_mode   = '0;
    b16.out_ready = 1'b1;
    test_reset();
    test_exact();
    test_approx();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
